bus_master_dma: RTL

- Bus-initiator copy engine that sits on one master port of the two-master shared bus, as master 0 or master 1.
- Requests the bus from the arbiter and holds the request while it owns the bus.
- Copies LEN words from SRC to DST, one read phase and one write phase per word, then releases the bus and pulses done.
- Acts as the requester/initiator end of the arbiter's req/grant handshake.

---
 rtl/bus_master_dma.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bus_master_dma.sv
// bus_master_dma: shared-bus initiator that copies len words from src to dst.
// Optional macro BUS_MASTER_DMA_FAIR_EN releases the bus for one cycle between words.
module bus_master_dma #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              m_req,
    input  logic              m_grant,
    output logic              m_cmd,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_RDW  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_REL  = 3'd6;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_data;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr;

    assign w_last = (r_idx == (r_len - LEN_W'(1)));

    // Next-state decode; grant loss simply holds the current phase.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (len != '0) ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                if (m_grant) begin
                    w_next = S_RD;
                end
            end
            S_RD: begin
                if (m_grant) begin
                    w_next = S_RDW;
                end
            end
            S_RDW: begin
                w_next = S_WR;
            end
            S_WR: begin
                if (m_grant) begin
                    if (w_last) begin
                        w_next = S_DONE;
                    end else begin
`ifdef BUS_MASTER_DMA_FAIR_EN
                        w_next = S_REL;
`else
                        w_next = S_RD;
`endif
                    end
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            S_REL: begin
                w_next = S_REQ;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register, descriptor latch, word index and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start && len != '0) begin
                r_src <= src_addr;
                r_dst <= dst_addr;
                r_len <= len;
                r_idx <= '0;
            end
            if (r_state == S_RDW) begin
                r_data <= m_din;
            end
            if (r_state == S_WR && m_grant && !w_last) begin
                r_idx <= r_idx + LEN_W'(1);
            end
        end
    end

    // Bus address: source side in RD, destination side in WR, wrapping in ADDR_W bits.
    always_comb begin
        w_addr = '0;
        if (r_state == S_RD) begin
            w_addr = r_src + ADDR_W'(r_idx);
        end else if (r_state == S_WR) begin
            w_addr = r_dst + ADDR_W'(r_idx);
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign m_req  = (r_state == S_REQ) || (r_state == S_RD) ||
                    (r_state == S_RDW) || (r_state == S_WR);
    assign m_wr   = (r_state == S_WR);
    assign m_cmd  = ((r_state == S_RD) || (r_state == S_WR)) && m_grant;
    assign m_addr = w_addr;
    assign m_dout = r_data;

endmodule
